timer_counter: RTL and testbench

Memory-mapped countdown timer that sits directly downstream of the CPU-side address bridge as one of its two device slots (DEV0 at 0x7f00–0x7f08, DEV1 at 0x7f10–0x7f18). It decodes the word offset, accepts register writes, returns read data to the bridge, and raises an interrupt request when the count expires. It supports one-shot and auto-reload modes. Two instances are built, one per slot.

---
 rtl/timer_counter.sv | 100 ++++++++++
 tb/tb_timer_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer for one bridge device slot.
// Supports one-shot and auto-reload modes with a maskable level interrupt.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for En
//   LOAD  | COUNT <= PRESET, irq_flag cleared
//   CNT   | counting down while En; expires at COUNT <= 1
//   INT   | expiry cycle; one-shot drops En, auto-reload drops irq_flag
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        en, im, auto_reload;
  logic        wr_ctrl, wr_preset, expire;
  logic        unused_addr;

  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign im          = ctrl[3];
  assign wr_ctrl     = WE && (Addr[3:2] == 2'b00);
  assign wr_preset   = WE && (Addr[3:2] == 2'b01);
  assign expire      = (state == CNT) && en && (count <= 32'd1);
  assign unused_addr = ^Addr[31:4];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: state_nxt = CNT;
      CNT: begin
        if (!en)        state_nxt = IDLE;
        else if (expire) state_nxt = INT;
      end
      INT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bus writes take priority over the FSM dropping En; the FSM setting
  // irq_flag takes priority over any clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= 4'h0;
      preset   <= 32'h0;
      count    <= 32'h0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_ctrl)
        ctrl <= Din[3:0];
      else if (state == INT && !auto_reload)
        ctrl[0] <= 1'b0;

      if (wr_preset)
        preset <= Din;

      if (state == LOAD)
        count <= preset;
      else if (state == CNT && en)
        count <= expire ? 32'h0 : count - 32'd1;

      if (expire)
        irq_flag <= 1'b1;
      else if (state == LOAD || (state == INT && auto_reload) || wr_ctrl || wr_preset)
        irq_flag <= 1'b0;
    end
  end

  always_comb begin
    Dout = 32'h0;
    case (Addr[3:2])
      2'b00:   Dout = {28'h0, ctrl};
      2'b01:   Dout = preset;
      2'b10:   Dout = count;
      default: Dout = 32'h0;
    endcase
  end

  assign IRQ = irq_flag & im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: expected COUNT/IRQ per cycle are
// queued when a sequence is started and popped as each edge is observed.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  typedef struct {
    logic [31:0] count;
    logic        irq;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [1:0] off, output logic [31:0] d);
    Addr = {28'h00007f0, off};
    #1;
    d = Dout;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
    Addr = {28'h00007f0, off};
    Din  = data;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    Din  = 32'h0;
  endtask

  task automatic push_exp(input logic [31:0] c, input logic i);
    exp_t e;
    e.count = c;
    e.irq   = i;
    sb_q.push_back(e);
  endtask

  task automatic run_and_check(input string tag, input int n);
    exp_t        e;
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      step();
      read_reg(2'b10, d);
      if (sb_q.size() == 0) begin
        check_eq({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq({tag, "_count"}, d, e.count);
        check_eq({tag, "_irq"}, {31'b0, IRQ}, {31'b0, e.irq});
      end
    end
  endtask

  initial begin
    int cnt_tbl[6];
    cnt_tbl = '{0, 3, 2, 1, 0, 0};

    reset = 1'b0;
    WE    = 1'b0;
    Addr  = '0;
    Din   = 32'h0;

    // reset held with bus activity
    for (int i = 0; i < 3; i++) begin
      WE   = ~WE;
      Addr = {28'h00007f0, 2'($urandom_range(0, 3))};
      Din  = $urandom;
      step();
      WE = 1'b0;
      for (int o = 0; o < 4; o++) begin
        read_reg(2'(o), rd);
        check_eq("rst_dout", rd, 32'h0);
      end
      check_eq("rst_irq", {31'b0, IRQ}, 32'h0);
    end
    reset = 1'b1;
    step();
    read_reg(2'b00, rd);
    check_eq("rst_ctrl", rd, 32'h0);

    // one-shot, PRESET=5
    bus_write(2'b01, 32'd5);
    bus_write(2'b00, 32'h9);
    for (int e = 1; e <= 8; e++)
      push_exp((e == 1) ? 32'd0 : (e <= 7 ? 32'(7 - e) : 32'd0), e >= 7);
    run_and_check("oneshot", 8);
    read_reg(2'b00, rd);
    check_eq("oneshot_ctrl", rd, 32'h8);
    push_exp(32'd0, 1'b1);
    push_exp(32'd0, 1'b1);
    run_and_check("oneshot_hold", 2);
    bus_write(2'b00, 32'h8);
    check_eq("oneshot_ack_irq", {31'b0, IRQ}, 32'h0);

    // auto-reload, PRESET=3: period 6
    bus_write(2'b01, 32'd3);
    bus_write(2'b00, 32'hB);
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 6; p++)
        push_exp(32'(cnt_tbl[p]), p == 4);
    run_and_check("auto", 18);
    bus_write(2'b00, 32'h8);
    step();
    step();
    check_eq("auto_stop_irq", {31'b0, IRQ}, 32'h0);
    read_reg(2'b10, rd);
    check_eq("auto_stop_count", rd, 32'd3);

    // pause at 6, then re-enable reloads 10
    bus_write(2'b01, 32'd10);
    bus_write(2'b00, 32'h9);
    push_exp(32'd3, 1'b0);
    for (int e = 2; e <= 5; e++)
      push_exp(32'(12 - e), 1'b0);
    run_and_check("pause_run", 5);
    bus_write(2'b00, 32'h8);
    read_reg(2'b10, rd);
    check_eq("pause_at", rd, 32'd6);
    for (int i = 0; i < 4; i++)
      push_exp(32'd6, 1'b0);
    run_and_check("pause_hold", 4);
    bus_write(2'b00, 32'h9);
    push_exp(32'd6, 1'b0);
    push_exp(32'd10, 1'b0);
    run_and_check("pause_reload", 2);
    bus_write(2'b01, 32'd20);
    read_reg(2'b10, rd);
    check_eq("preset_in_cnt", rd, 32'd9);
    bus_write(2'b00, 32'h8);
    step();
    read_reg(2'b10, rd);
    check_eq("pause2_hold", rd, 32'd8);

    // masked one-shot, PRESET=2
    bus_write(2'b01, 32'd2);
    bus_write(2'b00, 32'h1);
    push_exp(32'd8, 1'b0);
    push_exp(32'd2, 1'b0);
    push_exp(32'd1, 1'b0);
    push_exp(32'd0, 1'b0);
    push_exp(32'd0, 1'b0);
    run_and_check("masked", 5);
    read_reg(2'b00, rd);
    check_eq("masked_ctrl", rd, 32'h0);

    // decode
    bus_write(2'b10, 32'hFFFF);
    read_reg(2'b10, rd);
    check_eq("ro_count", rd, 32'd0);
    bus_write(2'b11, 32'hFFFF);
    read_reg(2'b11, rd);
    check_eq("rsvd_read", rd, 32'h0);
    read_reg(2'b00, rd);
    check_eq("rsvd_ctrl", rd, 32'h0);
    read_reg(2'b01, rd);
    check_eq("rsvd_preset", rd, 32'd2);

    // collisions: FSM set beats bus clear, bus CTRL beats FSM En clear
    bus_write(2'b00, 32'h9);
    push_exp(32'd0, 1'b0);
    push_exp(32'd2, 1'b0);
    push_exp(32'd1, 1'b0);
    run_and_check("coll_run", 3);
    bus_write(2'b01, 32'd2);
    check_eq("coll_set_wins", {31'b0, IRQ}, 32'h1);
    bus_write(2'b00, 32'h9);
    read_reg(2'b00, rd);
    check_eq("coll_ctrl_wins", rd, 32'h9);
    check_eq("coll_irq_clr", {31'b0, IRQ}, 32'h0);
    push_exp(32'd0, 1'b0);
    push_exp(32'd2, 1'b0);
    run_and_check("coll_reload", 2);
    bus_write(2'b00, 32'h8);
    step();
    read_reg(2'b10, rd);
    check_eq("coll_stop", rd, 32'd1);

    // async reset mid-count
    bus_write(2'b01, 32'd10);
    bus_write(2'b00, 32'h9);
    push_exp(32'd1, 1'b0);
    for (int e = 2; e <= 8; e++)
      push_exp(32'(12 - e), 1'b0);
    run_and_check("arst_run", 8);
    #2;
    reset = 1'b0;
    read_reg(2'b10, rd);
    check_eq("arst_count", rd, 32'd0);
    read_reg(2'b00, rd);
    check_eq("arst_ctrl", rd, 32'h0);
    check_eq("arst_irq", {31'b0, IRQ}, 32'h0);
    read_reg(2'b01, rd);
    check_eq("arst_preset", rd, 32'h0);
    reset = 1'b1;
    step();
    step();
    read_reg(2'b10, rd);
    check_eq("arst_after", rd, 32'd0);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
